rdec_strobe: RTL and testbench
==============================

# rdec_strobe

Parametrised register write-strobe sequencer. It accepts one write request at a time over a valid/ready handshake and drives the data bus. It then issues a single glitch-free, active-low latch-enable pulse to the addressed register, framed by programmable setup and hold intervals. It sits between the bus-side write port and the bank of external latch registers, and supersedes the clock-gated combinational address decoder.

## Interface
Parameters:
- ADDR_W, 3: address width.
- N_REG, 8: number of latch enables; legal range 1..2^ADDR_W.
- DATA_W, 8: width of the write data bus.
- SETUP_CYC, 1: cycles the bus is driven before the enable falls; 0 allowed.
- PULSE_CYC, 1: cycles the enable is held low; minimum 1.
- HOLD_CYC, 1: cycles the bus stays driven after the enable rises; 0 allowed.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  write request present.
- wr_ready  out  1  block can accept a request.
- wr_addr  in  ADDR_W  target register index.
- wr_data  in  DATA_W  write data.
- le_n  out  N_REG  active-low latch enables, registered.
- bus_data  out  DATA_W  data presented to the latches.
- bus_oe  out  1  bus drive enable.
- busy  out  1  a write sequence is in progress.
- err  out  1  one-cycle pulse: the accepted address was >= N_REG.

## Operation
- Reset values: le_n all ones, bus_data 0, bus_oe 0, busy 0, err 0, wr_ready 1, state IDLE.
- Handshake: a transfer occurs on a rising edge where wr_valid and wr_ready are both 1. wr_addr and wr_data are captured on that edge. wr_ready = (state == IDLE).
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE, legal accept: go to SETUP, or to STROBE if SETUP_CYC = 0.
  - SETUP: count SETUP_CYC cycles, then STROBE.
  - STROBE: count PULSE_CYC cycles, then HOLD, or IDLE if HOLD_CYC = 0.
  - HOLD: count HOLD_CYC cycles, then IDLE.
- Illegal address (wr_addr >= N_REG): the request is still accepted, so the handshake completes. err = 1 for exactly the next cycle. No bus drive, no strobe, state stays IDLE.
- Outputs per state:
  - bus_oe = 1 and bus_data = captured data in SETUP, STROBE and HOLD.
  - le_n[captured addr] = 0 only in STROBE. All other bits are 1 at all times.
  - busy = 1 in any state other than IDLE.
  - bus_data holds its last value in IDLE, and bus_oe is 0 in IDLE.
- Exactly one le_n bit is low at any time, or none.
- All outputs come from flops. No combinational path from clk or inputs to le_n.
- Counter: a single down-counter of width $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). It is loaded on each state entry and the state is left when the counter reaches 1.

## Timing
- Accept at edge T0, legal address: SETUP covers cycles T0+1 .. T0+SETUP_CYC.
- The le_n bit falls at the edge T0+SETUP_CYC+1 and rises after PULSE_CYC cycles.
- busy spans SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. wr_ready returns high on the following edge.
- Back-to-back writes: a request held valid is accepted on the first IDLE edge. The minimum request period is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- wr_valid while busy: ignored; the requester must hold it. Changes to wr_addr/wr_data while busy have no effect.
- Reset mid-operation: le_n goes to all ones and bus_oe to 0 immediately (asynchronously). The FSM returns to IDLE and the in-flight write is dropped.
- The one-cycle IDLE gap between sequences guarantees le_n is never low on two consecutive sequences without an intervening high cycle.

## Structure
- Package rdec_pkg holds the state enum (IDLE, SETUP, STROBE, HOLD) and a function returning the counter width from the three cycle parameters.
- Sub-module rdec_onehot (combinational, parameters ADDR_W and N_REG): converts an index to an N_REG-bit one-hot value, all zeros when the index is out of range. The top inverts and registers the result into le_n.
- Elaboration-time check: N_REG <= 2^ADDR_W and PULSE_CYC >= 1.

## Test plan
- Defaults; write addr 5, data 0xA5. Required response:
  - le_n = 0xDF for exactly 1 cycle, two cycles after accept.
  - bus_oe high for 3 cycles with bus_data = 0xA5.
  - wr_ready low for 3 cycles.
- SETUP_CYC=0, PULSE_CYC=3, HOLD_CYC=0; write addr 0. Required response:
  - le_n = 0xFE on cycles T0+1..T0+3.
  - busy exactly 3 cycles.
- N_REG=6; write addr 7. Required response:
  - handshake completes, err = 1 for one cycle.
  - le_n stays 0xFF (6-bit: 0x3F), bus_oe stays 0, busy stays 0.
- wr_valid held high continuously with addresses 1, 2, 3 (defaults). Required response:
  - three strobes spaced 4 cycles apart, each on the correct bit.
  - le_n never low on two adjacent sequences without a high cycle between.
- rst_n asserted during STROBE of addr 4. Required response:
  - le_n = 0xFF and bus_oe = 0 before the next edge.
  - after release, wr_ready = 1 and no residual strobe.
- Randomised back-to-back traffic with a scoreboard. Required response:
  - every legal write produces exactly one strobe on the matching bit with matching bus_data.
  - never more than one le_n bit low at once.

Source files
------------

// File: rtl/rdec_pkg.sv
// Shared types and helpers for the rdec_strobe write-strobe sequencer.
package rdec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } rdec_state_e;

  // Width of the shared phase down-counter: wide enough for the longest phase.
  function automatic int rdec_cnt_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rdec_onehot.sv
// Index to one-hot converter; indices at or above N_REG give all zeros.
module rdec_onehot
  import rdec_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int N_REG  = 8
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [N_REG-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (int'(idx) == i) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rdec_strobe.sv
// Register write-strobe sequencer: accepts one write, drives the bus and issues
// a single active-low latch-enable pulse framed by setup and hold intervals.
module rdec_strobe
  import rdec_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int N_REG     = 8,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [N_REG-1:0]  le_n,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_oe,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = rdec_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0]  SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0]  PULSE_LD = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   N_REG_W  = (ADDR_W+1)'(N_REG);

  if (N_REG < 1 || N_REG > (1 << ADDR_W) || PULSE_CYC < 1 ||
      SETUP_CYC < 0 || HOLD_CYC < 0) begin : g_param_chk
    $error("rdec_strobe: illegal parameter combination");
  end

  rdec_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  bus_data_q, bus_data_d;
  logic [N_REG-1:0]   le_n_q, le_n_d;
  logic               bus_oe_q, bus_oe_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               accept, legal;
  logic [N_REG-1:0]   strobe_oh;

  // Handshake: a transfer happens on a rising edge with wr_valid && wr_ready;
  // wr_addr/wr_data are sampled on that edge and ignored at all other times.
  assign accept = wr_valid & ready_q;
  assign legal  = ({1'b0, wr_addr} < N_REG_W);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    bus_data_d = bus_data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = ~legal;
          if (legal) begin
            addr_d     = wr_addr;
            bus_data_d = wr_data;
            if (SETUP_CYC > 0) begin
              state_d = SETUP;
              cnt_d   = SETUP_LD;
            end else begin
              state_d = STROBE;
              cnt_d   = PULSE_LD;
            end
          end
        end
      end
      SETUP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = STROBE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_ONE) begin
          if (HOLD_CYC > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_ONE) state_d = IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  rdec_onehot #(
    .ADDR_W (ADDR_W),
    .N_REG  (N_REG)
  ) u_onehot (
    .idx    (addr_d),
    .onehot (strobe_oh)
  );

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    le_n_d   = (state_d == STROBE) ? ~strobe_oh : '1;
    bus_oe_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
    ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      bus_data_q <= '0;
      le_n_q     <= '1;
      bus_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      bus_data_q <= bus_data_d;
      le_n_q     <= le_n_d;
      bus_oe_q   <= bus_oe_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign wr_ready = ready_q;
  assign le_n     = le_n_q;
  assign bus_data = bus_data_q;
  assign bus_oe   = bus_oe_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rdec_strobe.sv
// Bench for rdec_strobe: timeline reference model plus strobe scoreboard on the
// main instance, directed checks on a zero-setup/zero-hold instance.
module tb_rdec_strobe;

  localparam int AW = 3;
  localparam int NR = 6;
  localparam int DW = 8;
  localparam int SC = 1;
  localparam int PC = 1;
  localparam int HC = 1;
  localparam int L  = SC + PC + HC;
  localparam int EW = 32 + AW + DW;
  localparam logic [NR-1:0] ONES = '1;

  logic          clk, rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] le_n;
  logic [DW-1:0] bus_data;
  logic          bus_oe, busy, err;

  logic          w2_valid, w2_ready;
  logic [2:0]    w2_addr;
  logic [7:0]    w2_data;
  logic [7:0]    le2_n;
  logic [7:0]    bus2_data;
  logic          bus2_oe, busy2, err2;

  rdec_strobe #(
    .ADDR_W(AW), .N_REG(NR), .DATA_W(DW),
    .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .le_n(le_n), .bus_data(bus_data),
    .bus_oe(bus_oe), .busy(busy), .err(err)
  );

  rdec_strobe #(
    .ADDR_W(3), .N_REG(8), .DATA_W(8),
    .SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(w2_valid), .wr_ready(w2_ready),
    .wr_addr(w2_addr), .wr_data(w2_data), .le_n(le2_n), .bus_data(bus2_data),
    .bus_oe(bus2_oe), .busy(busy2), .err(err2)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (cycle k = interval after edge k) ----------------
  int cyc = 0;
  int next_free = 0;
  int busy_until = -1;
  int err_cyc = -1;
  int st_lo = -1, st_hi = -2, st_addr = 0;
  logic [DW-1:0] last_data = '0;
  logic [EW-1:0] exp_q[$];
  int st_starts[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      next_free  = 0;
      busy_until = -1;
      err_cyc    = -1;
      st_lo      = -1;
      st_hi      = -2;
    end else if (wr_valid && cyc >= next_free) begin
      if (int'(wr_addr) < NR) begin
        exp_q.push_back({cyc[31:0], wr_addr, wr_data});
        next_free  = cyc + L + 1;
        busy_until = cyc + L - 1;
        st_lo      = cyc + SC;
        st_hi      = cyc + SC + PC - 1;
        st_addr    = int'(wr_addr);
        last_data  = wr_data;
      end else begin
        err_cyc   = cyc;
        next_free = cyc + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NR-1:0] prev_le = '1;
  int            strobe_start = 0;

  always @(negedge clk) begin
    int k;
    logic [EW-1:0] e;
    logic [NR-1:0] exp_le;
    int t;
    k = cyc;
    if (!rst_n) begin
      prev_le = ONES;
    end else begin
      exp_le = (k >= st_lo && k <= st_hi) ? (ONES & ~(NR'(1) << st_addr)) : ONES;
      chk("wr_ready", 32'(wr_ready), 32'(k + 1 >= next_free));
      chk("busy",     32'(busy),     32'(k <= busy_until));
      chk("bus_oe",   32'(bus_oe),   32'(k <= busy_until));
      chk("err",      32'(err),      32'(k == err_cyc));
      chk("le_n",     32'(le_n),     32'(exp_le));
      chk("le_n_single_low", 32'($countones(~le_n) <= 1), 32'(1));
      if (k <= busy_until) chk("bus_data", 32'(bus_data), 32'(last_data));
      if (le_n != ONES && prev_le == ONES) begin
        st_starts.push_back(k);
        strobe_start = k;
        if (exp_q.size() == 0) begin
          chk("spurious_strobe", 32'(le_n), 32'(ONES));
        end else begin
          e = exp_q.pop_front();
          t = int'(e[EW-1 -: 32]);
          chk("sb_strobe_bit", 32'(le_n), 32'(ONES & ~(NR'(1) << e[DW +: AW])));
          chk("sb_bus_data",   32'(bus_data), 32'(e[DW-1:0]));
          chk("sb_latency",    32'(k - t), 32'(SC));
        end
      end
      if (le_n == ONES && prev_le != ONES) chk("pulse_len", 32'(k - strobe_start), 32'(PC));
      prev_le = le_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'(1));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    w2_valid = 1'b0; w2_addr = '0; w2_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_le_n",     32'(le_n), 32'(ONES));
    chk("rst_bus_data", 32'(bus_data), 32'(0));
    chk("rst_bus_oe",   32'(bus_oe), 32'(0));
    chk("rst_busy",     32'(busy), 32'(0));
    chk("rst_err",      32'(err), 32'(0));
    chk("rst_ready",    32'(wr_ready), 32'(1));
    chk("rst_le2_n",    32'(le2_n), 32'(8'hFF));

    // Single write, addr 5 / 0xA5.
    do_write(3'd5, 8'hA5);
    idle(5);

    // Illegal address: handshake completes, err pulse, no sequence.
    do_write(3'd7, 8'h11);
    idle(4);

    // Valid held high across three back-to-back writes.
    st_starts.delete();
    do_write(3'd1, 8'h01);
    do_write(3'd2, 8'h02);
    do_write(3'd3, 8'h03);
    idle(6);
    chk("b2b_count", 32'(st_starts.size()), 32'(3));
    if (st_starts.size() == 3) begin
      chk("b2b_gap0", 32'(st_starts[1] - st_starts[0]), 32'(L + 1));
      chk("b2b_gap1", 32'(st_starts[2] - st_starts[1]), 32'(L + 1));
    end

    // Zero-setup / zero-hold instance: strobe for three cycles right after accept.
    w2_valid = 1'b1; w2_addr = 3'd0; w2_data = 8'h3C;
    @(negedge clk);
    w2_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("z_le_n",   32'(le2_n),   (i < 3) ? 32'h0FE : 32'h0FF);
      chk("z_busy",   32'(busy2),   32'(i < 3));
      chk("z_bus_oe", 32'(bus2_oe), 32'(i < 3));
      if (i < 3) chk("z_bus_data", 32'(bus2_data), 32'h3C);
      @(negedge clk);
    end

    // Asynchronous reset during the strobe of addr 4.
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 8'h5A;
    n = 0;
    while (le_n == ONES && n < 20) begin
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b0;
    chk("rst_mid_reached_strobe", 32'(le_n), 32'(ONES & ~(NR'(1) << 4)));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_le_n",   32'(le_n), 32'(ONES));
    chk("rst_mid_bus_oe", 32'(bus_oe), 32'(0));
    chk("rst_mid_busy",   32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(wr_ready), 32'(1));
    chk("rst_mid_le_after",    32'(le_n), 32'(ONES));
    idle(3);

    // Randomised traffic, legal and illegal addresses, varied gaps.
    for (int i = 0; i < 40; i++) begin
      do_write(AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 4));
    end
    idle(8);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
